round_sat_pipe: RTL

Multi-lane, pipelined requantiser. It converts double-width signed fixed-point products (Q(2I).(2F)) to single-width Q(I).(F) with a run-time-selectable rounding mode, saturation, per-lane saturation flags and a beat-level saturation counter. It sits between the PE-array MAC accumulators and the activation/writeback path, and replaces the combinational rounder where throughput and back-pressure are required.

---
 rtl/round_sat_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: multi-lane elastic requantiser.
// Converts signed Q(2I).(2F) lane products to Q(I).(F) with a selectable
// rounding mode (0 floor, 1 half-up, 2 half-even, 3 bypass), saturation,
// per-lane saturation flags and a saturating per-beat saturation counter.
// Two registered stages: stage 1 rounds, stage 2 saturates.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   mode              rounding mode, captured with each accepted beat
//   in_valid/ready    input handshake; in_ready is combinational from out_ready
//   in_data           LANES x 2W two's-complement lanes
//   out_valid/ready   output handshake
//   out_data/out_sat  LANES x W results and per-lane saturation flags
//   clr_stats         synchronous clear of sat_count (wins over a handshake)
//   sat_count         delivered beats with any saturated lane, sticks at max

// Per-lane datapath: round into stage 1, saturate into stage 2.
module round_sat_lane #(
  parameter int W = 16,
  parameter int F = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_ld1,     // stage 1 captures i_x
  input  logic           i_ld2,     // stage 2 captures stage 1
  input  logic [1:0]     i_mode,    // mode of the beat entering stage 1
  input  logic [1:0]     i_mode_s1, // mode of the beat held in stage 1
  input  logic [2*W-1:0] i_x,
  output logic [W-1:0]   o_data,
  output logic           o_sat
);
  localparam int XW = 2 * W;
  localparam int RW = XW - F + 1;  // one guard bit so s + inc cannot wrap

  logic          w_inc;
  logic [RW-1:0] w_r;
  logic [RW-1:0] r_r;
  logic [W-1:0]  r_byp;
  logic [RW-W:0] w_hi;
  logic          w_ovf;
  logic [W-1:0]  w_dat;

  always_comb begin
    w_inc = 1'b0;
    case (i_mode)
      2'd1:    w_inc = i_x[F-1];
      // ties go up only when the kept LSB is odd
      2'd2:    w_inc = i_x[F-1] & ((|i_x[F-2:0]) | i_x[F]);
      default: ;
    endcase
  end

  // x >>> F is just the top XW-F bits; sign-extend one more bit before adding
  assign w_r = {i_x[XW-1], i_x[XW-1:F]} + {{(RW-1){1'b0}}, w_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r   <= '0;
      r_byp <= '0;
    end else if (i_ld1) begin
      r_r   <= w_r;
      r_byp <= i_x[W-1:0];
    end
  end

  // fits in W bits iff all bits from the W-1 sign position upward agree
  assign w_hi  = r_r[RW-1:W-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_dat = r_r[W-1:0];
    if (i_mode_s1 == 2'd3)
      w_dat = r_byp;
    else if (w_ovf)
      w_dat = r_r[RW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data <= '0;
      o_sat  <= 1'b0;
    end else if (i_ld2) begin
      o_data <= w_dat;
      o_sat  <= (i_mode_s1 != 2'd3) && w_ovf;
    end
  end
endmodule

module round_sat_pipe #(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 9,
  parameter int LANES     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                mode,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [LANES*2*(INT_BITS+FRAC_BITS)-1:0]   in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [LANES*(INT_BITS+FRAC_BITS)-1:0]     out_data,
  output logic [LANES-1:0]                          out_sat,
  input  logic                                      clr_stats,
  output logic [CNT_W-1:0]                          sat_count
);
  localparam int W = INT_BITS + FRAC_BITS;

  logic [2:1] r_vld_pipe;  // [1] stage 1 valid, [2] stage 2 valid
  logic [1:0] r_mode1;
  logic       w_en1, w_en2, w_ld1, w_ld2, w_hs;

  assign w_en2     = !r_vld_pipe[2] || out_ready;
  assign w_en1     = !r_vld_pipe[1] || w_en2;
  assign w_ld1     = w_en1 && in_valid;
  assign w_ld2     = w_en2 && r_vld_pipe[1];
  assign in_ready  = w_en1;
  assign out_valid = r_vld_pipe[2];
  assign w_hs      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_mode1    <= '0;
    end else begin
      if (w_en1) r_vld_pipe[1] <= in_valid;
      if (w_en2) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_ld1) r_mode1 <= mode;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    round_sat_lane #(.W(W), .F(FRAC_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_ld1    (w_ld1),
      .i_ld2    (w_ld2),
      .i_mode   (mode),
      .i_mode_s1(r_mode1),
      .i_x      (in_data[k*2*W +: 2*W]),
      .o_data   (out_data[k*W +: W]),
      .o_sat    (out_sat[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_count <= '0;
    else if (clr_stats)
      sat_count <= '0;
    else if (w_hs && (|out_sat) && !(&sat_count))
      sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end
endmodule
